// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit seven-segment display controller.
// Scans one digit per REFRESH_DIV cycles, decodes hex, applies per-digit
// enables, leading-zero blanking and PWM dimming, and takes new display
// values over a valid/ready port that commits only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int PWM_BITS    = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                clock_100Mhz,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] number_i,
    input  logic [DIGITS-1:0]   dp_i,
    input  logic                load_valid_i,
    output logic                load_ready_o,
    input  logic [DIGITS-1:0]   digit_en_i,
    input  logic                lz_blank_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic [DIGITS-1:0]   AN,
    output logic [6:0]          SEG,
    output logic                DP,
    output logic                frame_tick_o
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);

    // Inactive level of the pin drivers, used for reset and dark slots.
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? '1 : '0;
    localparam logic              DP_OFF  = ACTIVE_LOW;

    // Hex to segment pattern, active-low, SEG[6]=a ... SEG[0]=g.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'b0000001;
            4'h1: seg_decode = 7'b1001111;
            4'h2: seg_decode = 7'b0010010;
            4'h3: seg_decode = 7'b0000110;
            4'h4: seg_decode = 7'b1001100;
            4'h5: seg_decode = 7'b0100100;
            4'h6: seg_decode = 7'b0100000;
            4'h7: seg_decode = 7'b0001111;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0000100;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b1100000;
            4'hC: seg_decode = 7'b0110001;
            4'hD: seg_decode = 7'b1000010;
            4'hE: seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic                pending_q;
    logic [4*DIGITS-1:0] pend_num_q, disp_num_q;
    logic [DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic presc_wrap, frame_tick, accept, pwm_on;
    logic zero_run, dark, dp_bit;
    logic [3:0]        nib;
    logic [DIGITS-1:0] an_lo;
    logic [6:0]        seg_lo;
    logic              dp_lo;

    assign presc_wrap   = (presc_q == LAST_PRESC);
    assign frame_tick   = presc_wrap && (idx_q == LAST_IDX);
    assign frame_tick_o = frame_tick;
    assign load_ready_o = !pending_q;
    assign accept       = load_valid_i && !pending_q;

    // Scan counter next state: prescaler wraps, then the digit index steps.
    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Prescaler, digit index and free-running PWM counter.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_q + 1'b1;
        end
    end

    // Load capture into the pending buffer and frame-synchronous commit.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 1'b0;
            pend_num_q <= '0;
            pend_dp_q  <= '0;
            disp_num_q <= '0;
            disp_dp_q  <= '0;
        end else begin
            if (accept) begin
                pend_num_q <= number_i;
                pend_dp_q  <= dp_i;
            end
            if (frame_tick && pending_q) begin
                disp_num_q <= pend_num_q;
                disp_dp_q  <= pend_dp_q;
            end
            // A load taken in the tick cycle waits for the next boundary.
            if (accept) begin
                pending_q <= 1'b1;
            end else if (frame_tick) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign pwm_on = (brightness_i == '1) || (pwm_q < brightness_i);

    // Select the current digit, decide blanking/enable, build active-low pin levels.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        zero_run = 1'b1;
        nib      = '0;
        dp_bit   = 1'b0;
        dark     = 1'b1;
        an_lo    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (disp_num_q[4*(DIGITS-k)-1 -: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                nib    = disp_num_q[4*(DIGITS-k)-1 -: 4];
                dp_bit = disp_dp_q[DIGITS-1-k];
                dark   = !digit_en_i[DIGITS-1-k]
                         || (lz_blank_i && (k != DIGITS - 1) && zero_run);
                an_lo[DIGITS-1-k] = dark || !pwm_on;
            end
        end
        seg_lo = dark ? 7'h7F : seg_decode(nib);
        dp_lo  = !(dp_bit && !dark);
        an_d   = ACTIVE_LOW ? an_lo  : ~an_lo;
        seg_d  = ACTIVE_LOW ? seg_lo : ~seg_lo;
        dp_d   = ACTIVE_LOW ? dp_lo  : ~dp_lo;
    end

    // Registered pin drivers, one cycle behind the scan state.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: DIGITS=4, REFRESH_DIV=4, PWM_BITS=2. A second
// instance with ACTIVE_LOW=0 covers the inverted pin polarity. Expected pin
// states for a whole frame are queued when a value is loaded and popped as
// the frame is scanned out.
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 4;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] number;
    logic [3:0]  dp;
    logic        valid, sel;
    logic [3:0]  en;
    logic        lz;
    logic [1:0]  bright;

    logic       valid1, valid2;
    logic       ready1, ready2, tick1, tick2, dp1, dp2;
    logic [3:0] an1, an2;
    logic [6:0] seg1, seg2;

    logic       o_ready, o_tick, o_dp;
    logic [3:0] o_an;
    logic [6:0] o_seg;

    int n_assert = 0;
    int n_fail   = 0;

    assign valid1  = valid && !sel;
    assign valid2  = valid && sel;
    assign o_ready = sel ? ready2 : ready1;
    assign o_tick  = sel ? tick2  : tick1;
    assign o_an    = sel ? an2    : an1;
    assign o_seg   = sel ? seg2   : seg1;
    assign o_dp    = sel ? dp2    : dp1;

    seg7_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .PWM_BITS(2), .ACTIVE_LOW(1'b1)) dut (
        .clock_100Mhz(clk), .reset_n(rst_n), .number_i(number), .dp_i(dp),
        .load_valid_i(valid1), .load_ready_o(ready1), .digit_en_i(en),
        .lz_blank_i(lz), .brightness_i(bright), .AN(an1), .SEG(seg1), .DP(dp1),
        .frame_tick_o(tick1)
    );

    seg7_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .PWM_BITS(2), .ACTIVE_LOW(1'b0)) dut_hi (
        .clock_100Mhz(clk), .reset_n(rst_n), .number_i(number), .dp_i(dp),
        .load_valid_i(valid2), .load_ready_o(ready2), .digit_en_i(en),
        .lz_blank_i(lz), .brightness_i(bright), .AN(an2), .SEG(seg2), .DP(dp2),
        .frame_tick_o(tick2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference seven-segment table, active-low abcdefg.
    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Queue the 16 expected pin states of one frame. PWM phase equals the
    // cycle position j inside a 4-cycle slot since both counters start at 0.
    task automatic push_frame(input logic [15:0] num, input logic [3:0] dpv,
                              input logic [3:0] e, input logic l,
                              input logic [1:0] b, input logic al);
        logic zp, dark, on;
        logic [3:0] nib;
        exp_t x;
        zp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nib  = num[4*(3-k) +: 4];
            zp   = zp && (nib == 4'h0);
            dark = !e[3-k] || (l && (k != 3) && zp);
            for (int j = 0; j < 4; j++) begin
                on   = !dark && ((b == 2'd3) || (j < int'(b)));
                x.an = 4'hF;
                if (on) x.an[3-k] = 1'b0;
                x.seg = dark ? 7'h7F : dec(nib);
                x.dp  = !(dpv[3-k] && !dark);
                if (!al) begin
                    x.an  = ~x.an;
                    x.seg = ~x.seg;
                    x.dp  = ~x.dp;
                end
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic pop_compare(input string tag, input int i);
        exp_t x;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_empty: observed 0 expected 1", tag);
        end
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check($sformatf("%s_an[%0d]", tag, i), 32'(o_an), 32'(x.an));
            check($sformatf("%s_seg[%0d]", tag, i), 32'(o_seg), 32'(x.seg));
            check($sformatf("%s_dp[%0d]", tag, i), 32'(o_dp), 32'(x.dp));
        end
    endtask

    // Leaves the bench at the negedge right after the frame-tick clock edge.
    task automatic wait_tick();
        bit seen = 1'b0;
        int cnt  = 0;
        while (!seen && cnt < 64) begin
            @(negedge clk);
            cnt++;
            if (o_tick) seen = 1'b1;
        end
        check("tick_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_frame(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pop_compare(tag, i);
        end
    endtask

    task automatic do_load(input logic [15:0] num, input logic [3:0] d);
        bit got = 1'b0;
        int cnt = 0;
        number = num;
        dp     = d;
        valid  = 1'b1;
        while (!got && cnt < 64) begin
            @(negedge clk);
            cnt++;
            if (o_ready) got = 1'b1;
        end
        check("load_ready", 32'(got), 32'd1);
        @(posedge clk);
        #1 valid = 1'b0;
        check("ready_low_after_accept", 32'(o_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        rst_n  = 1'b0;
        valid  = 1'b0;
        sel    = 1'b0;
        number = '0;
        dp     = '0;
        en     = 4'hF;
        lz     = 1'b0;
        bright = 2'd3;

        #22;
        check("rst_an", 32'(an1), 32'hF);
        check("rst_seg", 32'(seg1), 32'h7F);
        check("rst_dp", 32'(dp1), 32'd1);
        check("rst_ready", 32'(ready1), 32'd1);
        check("rst_tick", 32'(tick1), 32'd0);
        check("rst_hi_an", 32'(an2), 32'h0);
        check("rst_hi_seg", 32'(seg2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Leave a load pending, then reset mid-scan: outputs go dark at once.
        number = 16'h8888;
        valid  = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check("pend_ready", 32'(ready1), 32'd0);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an1), 32'hF);
        check("async_rst_seg", 32'(seg1), 32'h7F);
        check("async_rst_dp", 32'(dp1), 32'd1);
        check("async_rst_ready", 32'(ready1), 32'd1);
        check("async_rst_tick", 32'(tick1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Display and pending were cleared: the first frames show 0000.
        wait_tick();
        push_frame(16'h0000, 4'h0, en, lz, bright, 1'b1);
        run_frame("zero_after_rst");

        // Load 0x12AF and check the following frame.
        do_load(16'h12AF, 4'h0);
        wait_tick();
        push_frame(16'h12AF, 4'h0, en, lz, bright, 1'b1);
        run_frame("f12AF");

        // Load mid-frame: old value stays, ready low, held valid waits.
        wait_tick();
        push_frame(16'h12AF, 4'h0, en, lz, bright, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("mid_ready_before", 32'(o_ready), 32'd1);
                number = 16'h1234;
                valid  = 1'b1;
            end else if (i == 6) begin
                check("mid_ready_after", 32'(o_ready), 32'd0);
                number = 16'hBEEF;
            end else if (i > 6 && i < 15) begin
                check($sformatf("mid_ready_held[%0d]", i), 32'(o_ready), 32'd0);
            end else if (i == 15) begin
                check("ready_after_commit", 32'(o_ready), 32'd1);
            end
            pop_compare("hold12AF", i);
        end
        @(posedge clk);
        #1 valid = 1'b0;
        check("second_accepted", 32'(o_ready), 32'd0);
        push_frame(16'h1234, 4'h0, en, lz, bright, 1'b1);
        run_frame("f1234");
        wait_tick();
        push_frame(16'hBEEF, 4'h0, en, lz, bright, 1'b1);
        run_frame("fBEEF");

        // Leading-zero blanking.
        lz = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_tick();
        push_frame(16'h0050, 4'h0, en, lz, bright, 1'b1);
        run_frame("lz0050");
        do_load(16'h0000, 4'h0);
        wait_tick();
        push_frame(16'h0000, 4'h0, en, lz, bright, 1'b1);
        run_frame("lz0000");

        // Digit enable and decimal points; the dp of a disabled digit is dropped.
        lz = 1'b0;
        en = 4'b1011;
        do_load(16'h8888, 4'b0110);
        wait_tick();
        push_frame(16'h8888, 4'b0110, en, lz, bright, 1'b1);
        run_frame("en_dp");

        // Brightness 1/4 and fully dark.
        en = 4'hF;
        wait_tick();
        bright = 2'd1;
        push_frame(16'h8888, 4'b0110, en, lz, bright, 1'b1);
        run_frame("bright1");
        wait_tick();
        bright = 2'd0;
        push_frame(16'h8888, 4'b0110, en, lz, bright, 1'b1);
        run_frame("bright0");
        bright = 2'd3;

        // Exactly one frame tick per 16 cycles.
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (o_tick) ticks++;
        end
        check("tick_count_64", 32'(ticks), 32'd4);

        // Active-high instance showing 0x0001.
        sel = 1'b1;
        do_load(16'h0001, 4'h0);
        wait_tick();
        push_frame(16'h0001, 4'h0, en, lz, bright, 1'b0);
        run_frame("act_high");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
